// File: rtl/masku_operand_sequencer_pkg.sv
// Shared types and helpers for the mask-unit operand sequencer.
// Contents: element length, stall-counter width, FSM state enum and the
// elements-per-beat helper used at request accept.
package masku_operand_sequencer_pkg;

  localparam int unsigned ELEN                  = 64;
  localparam int unsigned MaskuSeqStallCntWidth = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } masku_seq_state_e;

  // Mask bits produced per lock-step beat of all lanes for a given element width.
  function automatic int unsigned masku_epb(input int unsigned nr_lanes, input logic [1:0] vsew);
    return (nr_lanes * 8) >> vsew;
  endfunction

endpackage

// File: rtl/masku_result_buffer.sv
// OR-accumulate result buffer for the mask operand sequencer.
// Ports: clk_i/rst_i (sync, active-high), clr_i clears the buffer,
// acc_i ORs data_i into it, otherwise the contents hold; data_o is the buffer.
module masku_result_buffer #(
  parameter int unsigned Width = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             acc_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] buf_q;

  // Compressed beats never overlap, so OR-ing places each beat at its pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      buf_q <= '0;
    end else if (acc_i) begin
      buf_q <= buf_q | data_i;
    end
  end

  assign data_o = buf_q;

endmodule

// File: rtl/masku_operand_sequencer.sv
// Mask-unit operand sequencer: accepts one mask instruction (vl, vsew),
// consumes lock-step ALU/FPU beats, drives the compress bit pointer and hands
// full or final result buffers to writeback.
// Ports: req_* instruction request, alu_* per-lane result beats,
// vrf_pnt_o bit pointer, wb_* result buffer handshake, busy_o/done_o status,
// stall_cnt_o writeback stall cycles.
// Optional: define MASKU_SEQ_STALL_CNT_EN to build the writeback stall counter;
// otherwise stall_cnt_o is tied to zero.
module masku_operand_sequencer
  import masku_operand_sequencer_pkg::*;
#(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned VlWidth = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [VlWidth-1:0]               req_vl_i,
  input  logic [1:0]                       req_vsew_i,
  input  logic [NrLanes-1:0]               alu_valid_i,
  output logic [NrLanes-1:0]               alu_ready_o,
  input  logic [NrLanes*ELEN-1:0]          alu_compressed_i,
  output logic [$clog2(NrLanes*ELEN):0]    vrf_pnt_o,
  output logic                             wb_valid_o,
  output logic [NrLanes*ELEN-1:0]          wb_data_o,
  input  logic                             wb_ready_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [MaskuSeqStallCntWidth-1:0] stall_cnt_o
);

  localparam int unsigned DpWidth  = NrLanes * ELEN;
  localparam int unsigned PntWidth = $clog2(DpWidth) + 1;

  masku_seq_state_e state_q, state_d;

  logic [PntWidth-1:0] pnt_q;
  logic [PntWidth-1:0] epb_q;
  logic [VlWidth-1:0]  remaining_q;
  logic                last_q;

  logic               accept;
  logic               fire;
  logic               wb_hs;
  logic               final_beat;
  logic               buf_full;
  logic [VlWidth-1:0] epb_vl;

  assign accept     = (state_q == IDLE) && req_valid_i;
  assign fire       = (state_q == ACCUM) && (&alu_valid_i);
  assign wb_hs      = (state_q == FLUSH) && wb_ready_i;
  assign epb_vl     = VlWidth'(epb_q);
  assign final_beat = remaining_q <= epb_vl;
  assign buf_full   = (pnt_q + epb_q) == PntWidth'(DpWidth);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = (req_vl_i == '0) ? DONE : ACCUM;
      ACCUM:   if (fire && (final_beat || buf_full)) state_d = FLUSH;
      FLUSH:   if (wb_ready_i) state_d = last_q ? DONE : ACCUM;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    req_ready_o = 1'b0;
    alu_ready_o = '0;
    wb_valid_o  = 1'b0;
    done_o      = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ACCUM:   alu_ready_o = '1;
      FLUSH:   wb_valid_o  = 1'b1;
      DONE:    done_o      = 1'b1;
      default: busy_o      = 1'b1;
    endcase
  end

  // Pointer, remaining-element and last-buffer bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pnt_q       <= '0;
      epb_q       <= '0;
      remaining_q <= '0;
      last_q      <= 1'b0;
    end else begin
      if (accept) begin
        epb_q       <= PntWidth'(masku_epb(NrLanes, req_vsew_i));
        remaining_q <= req_vl_i;
        last_q      <= 1'b0;
        pnt_q       <= '0;
      end
      if (fire) begin
        pnt_q       <= pnt_q + epb_q;
        // Saturate at zero on the final (possibly partial) beat.
        remaining_q <= final_beat ? '0 : remaining_q - epb_vl;
        if (final_beat) last_q <= 1'b1;
      end
      if (wb_hs) begin
        pnt_q <= '0;
      end
    end
  end

  masku_result_buffer #(
    .Width(DpWidth)
  ) i_result_buffer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (wb_hs),
    .acc_i (fire),
    .data_i(alu_compressed_i),
    .data_o(wb_data_o)
  );

  assign vrf_pnt_o = pnt_q;

`ifdef MASKU_SEQ_STALL_CNT_EN
  logic [MaskuSeqStallCntWidth-1:0] stall_cnt_q;

  // Saturating count of cycles the writeback path holds off a valid buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if ((state_q == FLUSH) && !wb_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + MaskuSeqStallCntWidth'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/masku_operand_sequencer.md
Name: masku_operand_sequencer

Overview:
- Controller that sequences the mask-unit operand/compress datapath for mask-producing instructions (compares, carries, FP compares).
- Accepts one instruction at a time (vl, vsew) and drives the bit pointer `vrf_pnt_o` consumed by the compress logic.
- Consumes ALU/FPU result beats from all lanes in lock-step and ORs the already-compressed, shuffled beat into a DATAPATH_WIDTH result buffer.
- Hands a full or final buffer to the mask writeback path over a valid/ready handshake.

Parameters:
- NrLanes, 4, number of lanes; power of two, 1..16. DATAPATH_WIDTH = NrLanes*ELEN (ELEN=64 from ara_pkg).
- VlWidth, 16, width of the vector-length field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  new mask instruction valid
- req_ready_o  out  1  sequencer idle, request accepted
- req_vl_i  in  VlWidth  number of elements to process
- req_vsew_i  in  2  element width (vew_e: 0=8b .. 3=64b)
- alu_valid_i  in  NrLanes  per-lane result beat valid
- alu_ready_o  out  NrLanes  per-lane result beat ready; all bits always equal
- alu_compressed_i  in  DATAPATH_WIDTH  compressed, shuffled result bits for the current beat at the current `vrf_pnt_o`
- vrf_pnt_o  out  idx_width(DATAPATH_WIDTH)+1  bit pointer into the result buffer
- wb_valid_o  out  1  result buffer valid
- wb_data_o  out  DATAPATH_WIDTH  result buffer
- wb_ready_i  in  1  writeback accepts buffer
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the instruction completes
- stall_cnt_o  out  32  writeback stall cycles (see Optional Feature)

Behaviour:
- Reset: state=IDLE; buffer=0, vrf_pnt_o=0, remaining=0, last=0. Outputs: wb_valid_o=0, done_o=0, busy_o=0, alu_ready_o=0, req_ready_o=1, stall_cnt_o=0. Reset mid-operation abandons the instruction; no wb and no done are produced.
- Elements per beat: epb = (NrLanes*8) >> vsew. Registered at request accept.
- IDLE:
  - req_ready_o=1. On req_valid_i, latch vsew and remaining=vl.
  - If vl==0: go to DONE.
  - Otherwise: go to ACCUM.
- ACCUM:
  - alu_ready_o='1.
  - fire = &alu_valid_i. Partial valid never fires and produces no state change.
  - On fire:
    - buffer |= alu_compressed_i; vrf_pnt += epb; remaining -= min(epb, remaining).
    - If remaining <= epb (final beat), set last=1 and go to FLUSH.
    - Else if vrf_pnt+epb == DATAPATH_WIDTH (buffer full), go to FLUSH.
    - Both conditions may hold together; FLUSH then also carries last=1.
- FLUSH:
  - wb_valid_o=1, wb_data_o=buffer, alu_ready_o=0.
  - Hold wb_data_o stable until wb_ready_i.
  - On handshake: buffer=0, vrf_pnt=0. If last, go to DONE; else go to ACCUM.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Latency: wb_valid_o rises the cycle after the triggering fire. done_o rises the cycle after the final wb handshake, or 1 cycle after accept when vl==0.
- Tail bits above vl in the last buffer are passed unmodified; tail masking is downstream.
- Width rules: epb and DATAPATH_WIDTH are powers of two, so vrf_pnt never exceeds DATAPATH_WIDTH. remaining saturates at 0.

Optional Feature:
- Macro: MASKU_SEQ_STALL_CNT_EN.
- Defined: stall_cnt_o counts cycles in FLUSH with wb_ready_i=0. Saturating at 2^32-1; cleared only by reset.
- Undefined: stall_cnt_o tied to 0 and no counter flops are generated.

Decomposition:
- ara_pkg additions:
  - masku_seq_state_e {IDLE, ACCUM, FLUSH, DONE}.
  - MaskuSeqStallCntWidth=32.
  - Function masku_epb(NrLanes, vsew).
- One sub-module: masku_result_buffer. Holds the OR-accumulate register with clear and hold/valid. The FSM and counters stay in the top module.

Test Plan (NrLanes=4, DATAPATH_WIDTH=256):
1. vl=10, vsew=3, all lanes valid each cycle, wb_ready_i=1:
   - 3 fires with vrf_pnt_o 0,4,8.
   - One wb, wb_data_o equals the OR of the 3 beats.
   - done_o pulses once; vrf_pnt_o returns to 0.
2. vl=300, vsew=0 (epb=32):
   - 8 fires fill the buffer → wb #1.
   - 2 further fires (44 elements) → wb #2 with last set, then done_o.
   - Buffer is cleared between the two wbs.
3. Backpressure: FLUSH with wb_ready_i held low 5 cycles:
   - alu_ready_o=0 and wb_data_o stable throughout.
   - Handshake occurs on cycle 6.
   - With the macro, stall_cnt_o=5.
4. Partial valid: alu_valid_i=4'b0111 for 3 cycles, then 4'b1111:
   - No fire and no pointer change during the partial cycles.
   - Exactly one fire on the 4th cycle.
5. vl=0 request: req accepted; no wb_valid_o; done_o pulses 1 cycle later; back in IDLE.
6. rst_i asserted in FLUSH of scenario 2:
   - Next cycle all outputs are at reset values and no done_o.
   - A new request (vl=4, vsew=2) completes normally.
